rt_pixel_scheduler: RTL and testbench
=====================================

RT_PIXEL_SCHEDULER -- requirements
Module: rt_pixel_scheduler

Interface
REQ-001 Parameter H_RES, default 640: pixels per line; the X range is 0..H_RES-1.
REQ-002 Parameter V_RES, default 480: lines per frame; the Y range is 0..V_RES-1.
REQ-003 Port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port RESET_N, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port START, input, 1: single-cycle frame-start request.
REQ-006 Port BUSY, output, 1: high while a frame is in progress.
REQ-007 Port FRAME_DONE, output, 1: one-cycle pulse after the last pixel write of a frame.
REQ-008 Port FRAME_COUNT, output, 16: number of completed frames; wraps 0xFFFF -> 0.
REQ-009 Port CORE_ENABLE, output, 1: pixel request to the ray-tracing core.
REQ-010 Port CORE_X, output, 10: current pixel X.
REQ-011 Port CORE_Y, output, 9: current pixel Y.
REQ-012 Port CORE_READY, input, 1: core idle / result valid; high at idle, low while computing.
REQ-013 Port CORE_PIXEL, input, 4: core shade result; valid when CORE_READY returns high.
REQ-014 Port FB_WE, output, 1: framebuffer write strobe.
REQ-015 Port FB_ADDR, output, 19: linear address Y*H_RES+X.
REQ-016 Port FB_DATA, output, 4: pixel written to the framebuffer.
REQ-017 Port FB_READY, input, 1: framebuffer accepts the write in any cycle where FB_WE and FB_READY are both high.

Function
REQ-018 The FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, WRITE and ADVANCE.
REQ-019 IDLE: on START, load X=0, Y=0, ADDR=0, set BUSY, go to ISSUE.
REQ-020 ISSUE: assert CORE_ENABLE for exactly one cycle with CORE_X/CORE_Y valid, then go to WAIT_LOW.
REQ-021 WAIT_LOW: ignore CORE_READY while it is still high (the stale idle level); go to WAIT_HIGH when it is sampled low.
REQ-022 WAIT_HIGH: when CORE_READY is sampled high, capture CORE_PIXEL into FB_DATA and go to WRITE.
REQ-023 CORE_X and CORE_Y SHALL remain stable from ISSUE until exit from WAIT_HIGH.
REQ-024 WRITE: hold FB_WE high with stable FB_ADDR/FB_DATA until FB_READY is high; go to ADVANCE on acceptance.
REQ-025 ADVANCE: X increments; at X=H_RES-1, X wraps to 0 and Y increments; ADDR increments by 1 with no multiplier.
REQ-026 ADVANCE at X=H_RES-1 and Y=V_RES-1: pulse FRAME_DONE, increment FRAME_COUNT, clear BUSY, go to IDLE; otherwise go to ISSUE.
REQ-027 Latency from ISSUE to the next ISSUE SHALL be core latency + 4 cycles when FB_READY is held high.
REQ-028 START while BUSY SHALL be ignored; START in the same cycle FRAME_DONE pulses SHALL also be ignored.
REQ-029 Exactly H_RES*V_RES writes SHALL occur per frame, each address exactly once, in ascending order.
REQ-030 ADDR SHALL never exceed H_RES*V_RES-1.

Reset
REQ-031 RESET_N low SHALL asynchronously force state IDLE, BUSY=0, FRAME_DONE=0, FRAME_COUNT=0, CORE_ENABLE=0, CORE_X=0, CORE_Y=0, FB_WE=0, FB_ADDR=0, FB_DATA=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no FRAME_DONE; the next START restarts from pixel (0,0).
REQ-033 After RESET_N deasserts, the block SHALL start no frame until START is seen.

Structure
REQ-034 H_RES, V_RES, the pixel width (4), the address width (19) and the FSM state enum SHALL live in the shared package rt_pkg.
REQ-035 The X/Y/ADDR raster counter SHALL be the sub-module rt_raster_counter, with clear, advance and last-pixel flag.

Verification
REQ-036 Reset, then START with a core model of latency 5 and FB_READY=1 -> ISSUE-to-ISSUE spacing of 9 cycles, first write ADDR=0.
REQ-037 H_RES=4, V_RES=3 -> 12 writes at ADDR 0..11 in order, one FRAME_DONE pulse, FRAME_COUNT=1, BUSY low afterwards.
REQ-038 Core returns CORE_PIXEL=0xF for even X and 0x2 for odd X -> FB_DATA matches per address; FB_DATA=0x2 at ADDR 1.
REQ-039 FB_READY held low for 7 cycles during WRITE -> FB_WE, FB_ADDR and FB_DATA held stable; exactly one accepted write; no new ISSUE during the stall.
REQ-040 START pulsed mid-frame -> ignored; RESET_N low at pixel 5 then START -> writes restart at ADDR 0, FRAME_COUNT=0.
REQ-041 Core holds CORE_READY high for 2 cycles after CORE_ENABLE -> the scheduler stays in WAIT_LOW and captures no data until CORE_READY falls and rises again.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared constants and types for the ray-tracing pixel scheduler.
package rt_pkg;

    // Default raster geometry.
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    // Datapath widths.
    localparam int PIX_W  = 4;
    localparam int ADDR_W = 19;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [X_W-1:0]    x_t;
    typedef logic [Y_W-1:0]    y_t;

    // Scheduler states: one core request and one framebuffer write per pixel.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        WRITE,
        ADVANCE
    } state_t;

endpackage

// File: rtl/rt_raster_counter.sv
// Raster position counter: X/Y coordinates plus the matching linear address.
// The address is tracked incrementally so no Y*H_RES multiplier is needed.
module rt_raster_counter
    import rt_pkg::*;
#(
    parameter int H_RES = rt_pkg::H_RES,
    parameter int V_RES = rt_pkg::V_RES
) (
    input  logic  CLK,
    input  logic  RESET_N,
    input  logic  clear,
    input  logic  advance,
    output x_t    x,
    output y_t    y,
    output addr_t addr,
    output logic  last
);

    localparam x_t X_LAST = X_W'(H_RES - 1);
    localparam y_t Y_LAST = Y_W'(V_RES - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    // Step through the raster in row-major order; wrap to (0,0) after the last pixel.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y    <= '0;
                    addr <= '0;
                end else begin
                    y    <= y + 1'b1;
                    addr <= addr + 1'b1;
                end
            end else begin
                x    <= x + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rt_pixel_scheduler.sv
// Frame scheduler: walks every pixel, requests a shade from the ray-tracing
// core, waits for the result handshake and writes it to the framebuffer.
module rt_pixel_scheduler
    import rt_pkg::*;
#(
    parameter int H_RES = rt_pkg::H_RES,
    parameter int V_RES = rt_pkg::V_RES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic [15:0]       FRAME_COUNT,
    output logic              CORE_ENABLE,
    output logic [X_W-1:0]    CORE_X,
    output logic [Y_W-1:0]    CORE_Y,
    input  logic              CORE_READY,
    input  logic [PIX_W-1:0]  CORE_PIXEL,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [PIX_W-1:0]  FB_DATA,
    input  logic              FB_READY
);

    state_t state;
    logic   start_ok;
    logic   cnt_advance;
    logic   last_pixel;

    // A start request is honoured only from IDLE and not in the FRAME_DONE cycle.
    assign start_ok    = (state == IDLE) && START && !FRAME_DONE;
    assign cnt_advance = (state == ADVANCE);

    rt_raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clear   (start_ok),
        .advance (cnt_advance),
        .x       (CORE_X),
        .y       (CORE_Y),
        .addr    (FB_ADDR),
        .last    (last_pixel)
    );

    // Per-pixel handshake sequencer with registered control outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_COUNT <= '0;
            CORE_ENABLE <= 1'b0;
            FB_WE       <= 1'b0;
            FB_DATA     <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        BUSY        <= 1'b1;
                        CORE_ENABLE <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    CORE_ENABLE <= 1'b0;
                    state       <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // A high level here is the core's stale idle state, not a result.
                    if (!CORE_READY) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (CORE_READY) begin
                        FB_DATA <= CORE_PIXEL;
                        FB_WE   <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (FB_READY) begin
                        FB_WE <= 1'b0;
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (last_pixel) begin
                        FRAME_DONE  <= 1'b1;
                        FRAME_COUNT <= FRAME_COUNT + 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        CORE_ENABLE <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// Directed bench for rt_pixel_scheduler on a 4x3 raster with a latency-programmable core model.
module tb_rt_pixel_scheduler;

    localparam int TB_H = 4;
    localparam int TB_V = 3;
    localparam int NPIX = TB_H * TB_V;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [15:0] FRAME_COUNT;
    logic        CORE_ENABLE;
    logic [9:0]  CORE_X;
    logic [8:0]  CORE_Y;
    logic        CORE_READY;
    logic [3:0]  CORE_PIXEL;
    logic        FB_WE;
    logic [18:0] FB_ADDR;
    logic [3:0]  FB_DATA;
    logic        FB_READY;

    typedef struct {
        logic [18:0] addr;
        logic [3:0]  data;
    } wr_t;

    wr_t sb[$];
    int  issue_cyc[$];
    int  cyc        = 0;
    int  wr_count   = 0;
    int  done_cnt   = 0;
    int  errors     = 0;
    int  checks     = 0;
    int  core_lat   = 5;
    int  core_stale = 0;
    int  core_phase;
    int  core_cnt;
    logic [3:0] core_val;

    always #5 CLK = ~CLK;

    rt_pixel_scheduler #(
        .H_RES (TB_H),
        .V_RES (TB_V)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .BUSY        (BUSY),
        .FRAME_DONE  (FRAME_DONE),
        .FRAME_COUNT (FRAME_COUNT),
        .CORE_ENABLE (CORE_ENABLE),
        .CORE_X      (CORE_X),
        .CORE_Y      (CORE_Y),
        .CORE_READY  (CORE_READY),
        .CORE_PIXEL  (CORE_PIXEL),
        .FB_WE       (FB_WE),
        .FB_ADDR     (FB_ADDR),
        .FB_DATA     (FB_DATA),
        .FB_READY    (FB_READY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_pix(input int addr);
        return ((addr % TB_H) % 2 == 0) ? 4'hF : 4'h2;
    endfunction

    task automatic push_frame();
        wr_t w;
        for (int i = 0; i < NPIX; i++) begin
            w.addr = 19'(i);
            w.data = exp_pix(i);
            sb.push_back(w);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (wr_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("write_progress", 32'(ok), 32'd1);
    endtask

    // Returns one time unit after the edge that raised FRAME_DONE.
    task automatic wait_done(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (FRAME_DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_done_seen", 32'(ok), 32'd1);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Core model: optional stale-high window, then CORE_READY low for core_lat cycles.
    // CORE_PIXEL carries a poison value until the result is valid.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            core_phase <= 0;
            core_cnt   <= 0;
            CORE_READY <= 1'b1;
            CORE_PIXEL <= 4'h0;
            core_val   <= 4'h0;
        end else begin
            case (core_phase)
                0: begin
                    if (CORE_ENABLE) begin
                        core_val   <= CORE_X[0] ? 4'h2 : 4'hF;
                        CORE_PIXEL <= 4'h7;
                        if (core_stale > 0) begin
                            core_phase <= 1;
                            core_cnt   <= core_stale;
                        end else begin
                            core_phase <= 2;
                            core_cnt   <= core_lat;
                            CORE_READY <= 1'b0;
                        end
                    end
                end
                1: begin
                    if (core_cnt == 1) begin
                        core_phase <= 2;
                        core_cnt   <= core_lat;
                        CORE_READY <= 1'b0;
                    end else begin
                        core_cnt <= core_cnt - 1;
                    end
                end
                default: begin
                    if (core_cnt == 1) begin
                        core_phase <= 0;
                        CORE_READY <= 1'b1;
                        CORE_PIXEL <= core_val;
                    end else begin
                        core_cnt <= core_cnt - 1;
                    end
                end
            endcase
        end
    end

    // Monitor: issue coordinates, accepted writes against the scoreboard, done pulses.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (CORE_ENABLE) begin
                check("issue_x", 32'(CORE_X), 32'(issue_cyc.size() % TB_H));
                check("issue_y", 32'(CORE_Y), 32'(issue_cyc.size() / TB_H));
                issue_cyc.push_back(cyc);
            end
            if (FRAME_DONE) done_cnt++;
            if (FB_WE && FB_READY) begin
                wr_count++;
                check("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    wr_t w;
                    w = sb.pop_front();
                    check("fb_addr", 32'(FB_ADDR), 32'(w.addr));
                    check("fb_data", 32'(FB_DATA), 32'(w.data));
                end
            end
        end
    end

    initial begin
        int base_wr;
        int base_done;
        logic seen;

        RESET_N  = 1'b0;
        START    = 1'b0;
        FB_READY = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_busy",        32'(BUSY),        32'd0);
        check("rst_frame_done",  32'(FRAME_DONE),  32'd0);
        check("rst_frame_count", 32'(FRAME_COUNT), 32'd0);
        check("rst_core_enable", 32'(CORE_ENABLE), 32'd0);
        check("rst_core_x",      32'(CORE_X),      32'd0);
        check("rst_core_y",      32'(CORE_Y),      32'd0);
        check("rst_fb_we",       32'(FB_WE),       32'd0);
        check("rst_fb_addr",     32'(FB_ADDR),     32'd0);
        check("rst_fb_data",     32'(FB_DATA),     32'd0);
        RESET_N = 1'b1;

        // No frame starts without START
        repeat (5) step();
        check("idle_busy",     32'(BUSY),             32'd0);
        check("idle_no_issue", 32'(issue_cyc.size()), 32'd0);

        // Frame 1: latency 5, FB_READY high, mid-frame START ignored
        core_lat   = 5;
        core_stale = 0;
        base_wr    = wr_count;
        issue_cyc.delete();
        push_frame();
        pulse_start();
        check("f1_busy", 32'(BUSY), 32'd1);
        wait_writes(base_wr + 5, 200);
        pulse_start();
        wait_done(400);
        // START during the FRAME_DONE cycle must be ignored
        START = 1'b1;
        step();
        START = 1'b0;
        check("f1_done_one_cycle", 32'(FRAME_DONE),  32'd0);
        check("f1_frame_count",    32'(FRAME_COUNT), 32'd1);
        check("f1_busy_low",       32'(BUSY),        32'd0);
        repeat (4) step();
        check("f1_no_restart",     32'(BUSY),             32'd0);
        check("f1_issue_total",    32'(issue_cyc.size()), 32'(NPIX));
        check("f1_write_total",    32'(wr_count - base_wr), 32'(NPIX));
        check("f1_done_pulses",    32'(done_cnt),         32'd1);
        check("f1_sb_empty",       32'(sb.size()),        32'd0);
        for (int i = 1; i < issue_cyc.size(); i++) begin
            check("f1_issue_spacing", 32'(issue_cyc[i] - issue_cyc[i-1]), 32'(core_lat + 4));
        end

        // Frame 2: stale CORE_READY window, then a 7-cycle framebuffer stall
        core_lat   = 3;
        core_stale = 2;
        base_wr    = wr_count;
        issue_cyc.delete();
        push_frame();
        pulse_start();
        wait_writes(base_wr + 3, 200);
        FB_READY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (FB_WE === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("stall_we_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 7; i++) begin
            check("stall_we",       32'(FB_WE),       32'd1);
            check("stall_addr",     32'(FB_ADDR),     32'd3);
            check("stall_data",     32'(FB_DATA),     32'(exp_pix(3)));
            check("stall_no_issue", 32'(CORE_ENABLE), 32'd0);
            step();
        end
        check("stall_no_write", 32'(wr_count - base_wr), 32'd3);
        FB_READY = 1'b1;
        wait_done(400);
        step();
        check("f2_frame_count", 32'(FRAME_COUNT),          32'd2);
        check("f2_write_total", 32'(wr_count - base_wr),   32'(NPIX));
        check("f2_done_pulses", 32'(done_cnt),             32'd2);
        check("f2_sb_empty",    32'(sb.size()),            32'd0);
        check("f2_busy_low",    32'(BUSY),                 32'd0);

        // Frame 3: reset at pixel 5 abandons the frame
        core_lat   = 5;
        core_stale = 0;
        base_wr    = wr_count;
        issue_cyc.delete();
        push_frame();
        pulse_start();
        wait_writes(base_wr + 5, 200);
        RESET_N = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_frame_count", 32'(FRAME_COUNT), 32'd0);
        check("mid_rst_busy",        32'(BUSY),        32'd0);
        check("mid_rst_fb_we",       32'(FB_WE),       32'd0);
        check("mid_rst_fb_addr",     32'(FB_ADDR),     32'd0);
        check("mid_rst_core_enable", 32'(CORE_ENABLE), 32'd0);
        repeat (3) step();
        #2;
        RESET_N = 1'b1;
        issue_cyc.delete();
        base_done = done_cnt;
        repeat (4) step();
        check("post_rst_idle",     32'(BUSY),             32'd0);
        check("post_rst_no_issue", 32'(issue_cyc.size()), 32'd0);
        check("post_rst_no_done",  32'(done_cnt),         32'(base_done));

        // Frame 4: restart from pixel (0,0)
        base_wr = wr_count;
        push_frame();
        pulse_start();
        wait_done(400);
        step();
        check("f4_frame_count", 32'(FRAME_COUNT),        32'd1);
        check("f4_done_pulses", 32'(done_cnt - base_done), 32'd1);
        check("f4_write_total", 32'(wr_count - base_wr), 32'(NPIX));
        check("f4_sb_empty",    32'(sb.size()),          32'd0);
        check("f4_busy_low",    32'(BUSY),               32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
